pipe_mux_reg: RTL and testbench

Parametrised N-way registered multiplexer. It is the next-generation replacement for the fixed 2:1 32-bit registered mux used in the datapath. It adds a valid/ready handshake with a one-entry skid buffer, so a stalled consumer never drops data. It also adds a synchronous flush for pipeline squash and sticky detection of an out-of-range select. It sits between forwarding/operand-select logic and the next pipeline register stage.

---
 rtl/pipe_mux_reg_pkg.sv | 11 +
 rtl/pipe_mux_reg_skid_reg.sv | 54 +++++
 rtl/pipe_mux_reg.sv | 61 ++++++
 tb/tb_pipe_mux_reg.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_mux_reg_pkg.sv
// rtl/pipe_mux_reg_pkg.sv - shared pipeline-stage width and handshake helper
package pipe_mux_reg_pkg;

    localparam int STAGE_WIDTH = 32;

    // A word moves across a valid/ready pair only when both sides agree.
    function automatic logic hs_fire(input logic valid, input logic ready);
        return valid && ready;
    endfunction

endpackage

// File: rtl/pipe_mux_reg_skid_reg.sv
// rtl/pipe_mux_reg_skid_reg.sv - one-entry valid/ready skid register with flush
module skid_reg
    import pipe_mux_reg_pkg::*;
#(
    parameter int WIDTH = STAGE_WIDTH
) (
    input  logic             c,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic             accept;
    logic             drain;

    // in_ready depends on registered state only, so no path from out_ready.
    assign in_ready = !skid_valid;
    assign accept   = hs_fire(in_valid, in_ready) && !flush;
    assign drain    = hs_fire(out_valid, out_ready);

    always_ff @(posedge c) begin
        if (rst) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || drain) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe_mux_reg.sv
// rtl/pipe_mux_reg.sv - N-way registered mux with skid handshake, flush and sticky select error
module pipe_mux_reg
    import pipe_mux_reg_pkg::*;
#(
    parameter int  WIDTH  = STAGE_WIDTH,
    parameter int  NUM_IN = 4,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    c,
    input  logic                    rst,
    input  logic [WIDTH*NUM_IN-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    logic [WIDTH-1:0] mux_o;
    logic             sel_oob;
    logic             accept;

    // Unmatched selects fall through to zero, so an out-of-range word is still transferred as 0.
    always_comb begin
        mux_o = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                mux_o = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_oob = (32'(sel) >= 32'(NUM_IN));
    assign accept  = hs_fire(in_valid, in_ready) && !flush;

    always_ff @(posedge c) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else if (accept && sel_oob) begin
            sel_err <= 1'b1;
        end
    end

    skid_reg #(
        .WIDTH (WIDTH)
    ) u_skid (
        .c         (c),
        .rst       (rst),
        .flush     (flush),
        .in_data   (mux_o),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

endmodule

// File: tb/tb_pipe_mux_reg.sv
// tb/tb_pipe_mux_reg.sv - queue-model checked bench for pipe_mux_reg (4x32 and 3x8 instances)
module tb_pipe_mux_reg;

    localparam int WA = 32;
    localparam int NA = 4;
    localparam int WB = 8;
    localparam int NB = 3;

    logic c = 1'b0;
    always #5 c = ~c;

    logic rst;

    logic [WA*NA-1:0] a_in_data;
    logic [1:0]       a_sel;
    logic             a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_sel_err;
    logic [WA-1:0]    a_out_data;

    logic [WB*NB-1:0] b_in_data;
    logic [1:0]       b_sel;
    logic             b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_sel_err;
    logic [WB-1:0]    b_out_data;

    pipe_mux_reg #(.WIDTH(WA), .NUM_IN(NA)) dut_a (
        .c(c), .rst(rst), .in_data(a_in_data), .sel(a_sel), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .flush(a_flush), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .sel_err(a_sel_err)
    );

    pipe_mux_reg #(.WIDTH(WB), .NUM_IN(NB)) dut_b (
        .c(c), .rst(rst), .in_data(b_in_data), .sel(b_sel), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .flush(b_flush), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .sel_err(b_sel_err)
    );

    // Model: each block holds an ordered list of at most two words; the front is the output.
    logic [WA-1:0] qa[$];
    logic [WB-1:0] qb[$];
    logic [WA-1:0] a_last;
    logic [WB-1:0] b_last;
    bit            a_err, b_err;

    int errors = 0;
    int checks = 0;

    function automatic logic [WA-1:0] pick_a(input logic [WA*NA-1:0] d, input int s);
        return (s < NA) ? d[s*WA +: WA] : '0;
    endfunction

    function automatic logic [WB-1:0] pick_b(input logic [WB*NB-1:0] d, input int s);
        return (s < NB) ? d[s*WB +: WB] : '0;
    endfunction

    task automatic model_edge();
        bit acc;
        if (rst) begin
            qa.delete(); a_last = '0; a_err = 0;
            qb.delete(); b_last = '0; b_err = 0;
        end else begin
            if (a_flush) begin
                qa.delete();
            end else begin
                acc = a_in_valid && (qa.size() < 2);
                if (a_out_ready && qa.size() > 0) void'(qa.pop_front());
                if (acc) begin
                    qa.push_back(pick_a(a_in_data, int'(a_sel)));
                    if (int'(a_sel) >= NA) a_err = 1;
                end
            end
            if (b_flush) begin
                qb.delete();
            end else begin
                acc = b_in_valid && (qb.size() < 2);
                if (b_out_ready && qb.size() > 0) void'(qb.pop_front());
                if (acc) begin
                    qb.push_back(pick_b(b_in_data, int'(b_sel)));
                    if (int'(b_sel) >= NB) b_err = 1;
                end
            end
        end
        if (qa.size() > 0) a_last = qa[0];
        if (qb.size() > 0) b_last = qb[0];
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("a_out_valid", 64'(a_out_valid), 64'(qa.size() > 0));
        chk("a_in_ready",  64'(a_in_ready),  64'(qa.size() < 2));
        chk("a_out_data",  64'(a_out_data),  64'(a_last));
        chk("a_sel_err",   64'(a_sel_err),   64'(a_err));
        chk("b_out_valid", 64'(b_out_valid), 64'(qb.size() > 0));
        chk("b_in_ready",  64'(b_in_ready),  64'(qb.size() < 2));
        chk("b_out_data",  64'(b_out_data),  64'(b_last));
        chk("b_sel_err",   64'(b_sel_err),   64'(b_err));
    endtask

    task automatic cycle();
        @(posedge c);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic offer_a(input logic [WA-1:0] w);
        a_in_data  = {4{w}};
        a_sel      = 2'd0;
        a_in_valid = 1'b1;
    endtask

    logic [31:0] t1_exp [4] = '{32'h00, 32'h11, 32'h22, 32'h33};

    initial begin
        rst = 1'b1;
        a_in_data = '0; a_sel = '0; a_in_valid = 0; a_flush = 0; a_out_ready = 0;
        b_in_data = '0; b_sel = '0; b_in_valid = 0; b_flush = 0; b_out_ready = 0;
        cycle();
        rst = 1'b0;
        chk("reset out_valid", 64'(a_out_valid), 64'd0);
        chk("reset in_ready",  64'(a_in_ready),  64'd1);
        chk("reset out_data",  64'(a_out_data),  64'd0);
        chk("reset sel_err",   64'(b_sel_err),   64'd0);

        // Streaming through all four selects.
        a_out_ready = 1'b1;
        a_in_data   = {32'h33, 32'h22, 32'h11, 32'h00};
        a_in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_sel = 2'(i);
            cycle();
            chk("stream data",     64'(a_out_data), 64'(t1_exp[i]));
            chk("stream in_ready", 64'(a_in_ready), 64'd1);
        end
        a_in_valid = 1'b0;
        cycle();

        // Backpressure fills output and skid, then drains in order.
        a_out_ready = 1'b0;
        offer_a(32'hAAAA); cycle();
        offer_a(32'hBBBB); cycle();
        chk("skid held A", 64'(a_out_data), 64'hAAAA);
        chk("skid full",   64'(a_in_ready), 64'd0);
        offer_a(32'hCCCC); cycle();
        chk("stall held A", 64'(a_out_data), 64'hAAAA);
        a_out_ready = 1'b1;
        cycle();
        chk("drain B", 64'(a_out_data), 64'hBBBB);
        cycle();
        chk("drain C", 64'(a_out_data), 64'hCCCC);
        a_in_valid = 1'b0;
        cycle();

        // Flush with both entries full and a word offered alongside.
        a_out_ready = 1'b0;
        offer_a(32'h1111); cycle();
        offer_a(32'h2222); cycle();
        offer_a(32'hDDDD); a_flush = 1'b1; cycle();
        a_flush = 1'b0; a_in_valid = 1'b0;
        chk("flush out_valid", 64'(a_out_valid), 64'd0);
        chk("flush in_ready",  64'(a_in_ready),  64'd1);
        a_out_ready = 1'b1;
        repeat (3) cycle();

        // Reset asserted mid-cycle acts only on the next edge.
        a_out_ready = 1'b0;
        offer_a(32'h5555); cycle();
        offer_a(32'h6666); cycle();
        a_in_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk("rst before edge", 64'(a_out_valid), 64'd1);
        cycle();
        rst = 1'b0;
        chk("rst out_valid", 64'(a_out_valid), 64'd0);
        chk("rst in_ready",  64'(a_in_ready),  64'd1);
        chk("rst out_data",  64'(a_out_data),  64'd0);

        // Out-of-range select on the 3-input block.
        b_out_ready = 1'b1;
        b_in_data   = 24'hCCBBAA;
        b_sel       = 2'd3;
        b_in_valid  = 1'b1;
        cycle();
        chk("oob data",    64'(b_out_data), 64'd0);
        chk("oob sel_err", 64'(b_sel_err),  64'd1);
        b_sel = 2'd1;
        cycle();
        chk("in-range after oob", 64'(b_out_data), 64'hBB);
        chk("sel_err sticky",     64'(b_sel_err),  64'd1);

        // Random traffic with stalls and occasional flush on both blocks.
        for (int n = 0; n < 600; n++) begin
            a_in_data   = {$urandom, $urandom, $urandom, $urandom};
            a_sel       = 2'($urandom_range(0, 3));
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_out_ready = ($urandom_range(0, 2) != 0);
            a_flush     = ($urandom_range(0, 31) == 0);
            b_in_data   = 24'($urandom);
            b_sel       = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            b_in_valid  = ($urandom_range(0, 2) != 0);
            b_out_ready = ($urandom_range(0, 3) != 0);
            b_flush     = ($urandom_range(0, 31) == 0);
            cycle();
        end

        a_in_valid = 0; a_flush = 0; b_in_valid = 0; b_flush = 0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("sel_err cleared by rst", 64'(b_sel_err), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
